// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   XLEN_DEFAULT  default address/instruction width
//   NOP_INSTR     addi x0,x0,0; the instruction placed in IF/ID for a bubble
//   RESET_VECTOR  default fetch address after reset
//   fetch_state_e fetch FSM states
package fetch_unit_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  // FS_REQ : ready to issue a request
  // FS_WAIT: one request outstanding, its result will be used
  // FS_KILL: one request outstanding, its result will be discarded
  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_KILL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response channel.
//   imem_req_valid   request valid            (master -> slave)
//   imem_req_addr    request address          (master -> slave)
//   imem_req_ready   slave accepts request    (slave -> master)
//   imem_resp_valid  response valid, in order (slave -> master)
//   imem_resp_data   fetched instruction      (slave -> master)
interface fetch_unit_if #(
  parameter int unsigned XLEN = fetch_unit_pkg::XLEN_DEFAULT
);

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data
  );

endinterface

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register.
//   clk, reset           clock, synchronous active-high reset
//   load_en              update enable (decode not stalled)
//   flush                force a bubble, overrides load_en
//   in_valid             candidate instruction is real; 0 loads a bubble
//   in_instr/in_pc/in_pcplus4   candidate contents
//   instrD/pcD/pcplus4D/validD  register outputs to decode
module ifid_reg
  import fetch_unit_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_en,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pcplus4,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pcplus4D,
  output logic            validD
);

  always_ff @(posedge clk) begin
    if (reset || flush || (load_en && !in_valid)) begin
      validD   <= 1'b0;
      instrD   <= XLEN'(NOP_INSTR);
      pcD      <= '0;
      pcplus4D <= '0;
    end else if (load_en) begin
      validD   <= 1'b1;
      instrD   <= in_instr;
      pcD      <= in_pc;
      pcplus4D <= in_pcplus4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage plus IF/ID register of the 5-stage pipeline.
//   clk, reset       clock, synchronous active-high reset
//   stallF           hold pcF, issue no new request
//   stallD           hold IF/ID contents
//   redirect_valid   taken/mispredicted control transfer resolved in execute
//   redirect_pc      new fetch target (low two bits ignored)
//   imem             instruction memory channel (master side)
//   instrD/pcD/pcplus4D/validD   IF/ID register outputs
//   imem_wait        fetch is waiting on memory (status only)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_VECTOR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stallF,
  input  logic               stallD,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  fetch_unit_if.master       imem,
  output logic [XLEN-1:0]    instrD,
  output logic [XLEN-1:0]    pcD,
  output logic [XLEN-1:0]    pcplus4D,
  output logic               validD,
  output logic               imem_wait
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc_f, pc_seq;
  logic            hold_valid;
  logic [XLEN-1:0] hold_data, hold_pc;
  logic            req_valid, req_fire, resp_take;
  logic            ifid_valid_in;
  logic [XLEN-1:0] ifid_instr_in, ifid_pc_in;

  assign pc_seq = pc_f + XLEN'(4);

  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    resp_take = 1'b0;
    imem.imem_req_addr = pc_f;
    unique case (state)
      FS_REQ: begin
        // Gated by reset so no request is accepted that the FSM never tracks.
        req_valid = !stallF && !hold_valid && !redirect_valid && !reset;
        if (!redirect_valid && req_valid && imem.imem_req_ready)
          state_nxt = FS_WAIT;
      end
      FS_WAIT: begin
        if (redirect_valid) begin
          state_nxt = imem.imem_resp_valid ? FS_REQ : FS_KILL;
        end else if (imem.imem_resp_valid) begin
          resp_take = 1'b1;
          // Back-to-back issue also requires the returning instruction to go
          // straight into IF/ID; otherwise the single hold entry could be
          // needed twice.
          req_valid = !stallF && !stallD && !hold_valid && !reset;
          imem.imem_req_addr = pc_seq;
          state_nxt = (req_valid && imem.imem_req_ready) ? FS_WAIT : FS_REQ;
        end
      end
      FS_KILL: begin
        if (imem.imem_resp_valid && !redirect_valid)
          state_nxt = FS_REQ;
      end
      default: state_nxt = FS_REQ;
    endcase
  end

  assign imem.imem_req_valid = req_valid;
  assign req_fire  = req_valid && imem.imem_req_ready;
  assign imem_wait = (state == FS_WAIT && !imem.imem_resp_valid) ||
                     (state == FS_KILL) ||
                     (req_valid && !req_fire);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FS_REQ;
      pc_f       <= RESET_PC & ALIGN_MASK;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_pc    <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        pc_f       <= redirect_pc & ALIGN_MASK;
        hold_valid <= 1'b0;
      end else begin
        if (resp_take)
          pc_f <= pc_seq;
        if (resp_take && stallD) begin
          hold_valid <= 1'b1;
          hold_data  <= imem.imem_resp_data;
          hold_pc    <= pc_f;
        end else if (hold_valid && !stallD) begin
          hold_valid <= 1'b0;
        end
      end
    end
  end

  // Hold buffer is only occupied in FS_REQ, so it never competes with a response.
  assign ifid_valid_in = resp_take || hold_valid;
  assign ifid_instr_in = resp_take ? imem.imem_resp_data : hold_data;
  assign ifid_pc_in    = resp_take ? pc_f : hold_pc;

  ifid_reg #(.XLEN(XLEN)) u_ifid (
    .clk        (clk),
    .reset      (reset),
    .load_en    (!stallD),
    .flush      (redirect_valid),
    .in_valid   (ifid_valid_in),
    .in_instr   (ifid_instr_in),
    .in_pc      (ifid_pc_in),
    .in_pcplus4 (ifid_pc_in + XLEN'(4)),
    .instrD     (instrD),
    .pcD        (pcD),
    .pcplus4D   (pcplus4D),
    .validD     (validD)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, stallF, stallD, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instrD, pcD, pcplus4D;
  logic        validD, imem_wait;

  fetch_unit_if #(.XLEN(32)) imem ();

  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .stallF         (stallF),
    .stallD         (stallD),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .instrD         (instrD),
    .pcD            (pcD),
    .pcplus4D       (pcplus4D),
    .validD         (validD),
    .imem_wait      (imem_wait)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;
  int          lat;
  logic        pend;
  int          cnt;
  logic [31:0] pend_addr;
  logic        obs_fire, obs_req_valid, obs_wait;
  logic [31:0] obs_addr;
  logic [31:0] held;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: memory model drives its response, outputs are observed,
  // the scoreboard consumes what decode takes, then the edge happens.
  task automatic tick();
    exp_t e;
    imem.imem_resp_valid = pend && (cnt <= 1);
    imem.imem_resp_data  = imem.imem_resp_valid ? mem_data(pend_addr) : '0;
    if (pend && cnt > 1) cnt--;
    #1;
    obs_req_valid = imem.imem_req_valid;
    obs_addr      = imem.imem_req_addr;
    obs_fire      = imem.imem_req_valid && imem.imem_req_ready;
    obs_wait      = imem_wait;
    if (reset) begin
      sb_q.delete();
      exp_pc = RST_PC;
    end else if (redirect_valid) begin
      sb_q.delete();
      exp_pc = {redirect_pc[31:2], 2'b00};
    end else if (validD && !stallD) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("sb_pcD_model", pcD, exp_pc);
        chk("sb_pcD_req", pcD, e.pc);
        chk("sb_instrD", instrD, e.data);
        chk("sb_pcplus4D", pcplus4D, exp_pc + 32'd4);
      end
      exp_pc = exp_pc + 32'd4;
    end
    if (imem.imem_resp_valid) pend = 1'b0;
    if (obs_fire) begin
      sb_q.push_back('{pc: obs_addr, data: mem_data(obs_addr)});
      pend      = 1'b1;
      cnt       = lat;
      pend_addr = obs_addr;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick_until_fire(input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      tick();
      if (obs_fire) break;
    end
    chk({tag, "_fire"}, 32'(obs_fire), 32'd1);
  endtask

  task automatic tick_until_valid(input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      tick();
      if (validD) break;
    end
    chk({tag, "_valid"}, 32'(validD), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_validD"}, 32'(validD), 32'd0);
    chk({tag, "_instrD"}, instrD, NOP_INSTR);
    chk({tag, "_pcD"}, pcD, 32'd0);
    chk({tag, "_pcplus4D"}, pcplus4D, 32'd0);
  endtask

  initial begin
    reset = 1'b1; stallF = 1'b0; stallD = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem.imem_req_ready = 1'b1; imem.imem_resp_valid = 1'b0; imem.imem_resp_data = '0;
    lat = 1; pend = 1'b0; cnt = 0; pend_addr = '0; exp_pc = RST_PC;
    @(negedge clk);
    tick(); tick();
    chk_reset_outputs("reset");
    chk("reset_no_req", 32'(obs_req_valid), 32'd0);

    // 1. streaming with 1-cycle memory
    reset = 1'b0;
    tick();
    chk("t1_addr0", obs_addr, 32'h0);
    chk("t1_fire0", 32'(obs_fire), 32'd1);
    tick();
    chk("t1_addr4", obs_addr, 32'h4);
    chk("t1_pcD0", pcD, 32'h0);
    chk("t1_validD0", 32'(validD), 32'd1);
    tick();
    chk("t1_addr8", obs_addr, 32'h8);
    chk("t1_pcD4", pcD, 32'h4);

    // 2. combined stall while the response for 0x8 arrives
    stallF = 1'b1; stallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_no_req", 32'(obs_req_valid), 32'd0);
      chk("t2_pcD_held", pcD, 32'h4);
    end
    stallF = 1'b0; stallD = 1'b0;
    tick();
    chk("t2_pcD8", pcD, 32'h8);
    tick();
    tick_until_valid(10, "t2_c");
    chk("t2_pcDC", pcD, 32'hC);

    // 3. redirect while waiting, response arrives later and is discarded
    lat = 3;
    tick_until_fire(10, "t3_pre");
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("t3_bubble", 32'(validD), 32'd0);
    tick();
    chk("t3_kill_no_req", 32'(obs_req_valid), 32'd0);
    chk("t3_kill_wait", 32'(obs_wait), 32'd1);
    tick_until_fire(10, "t3");
    chk("t3_addr", obs_addr, 32'h100);
    chk("t3_still_bubble", 32'(validD), 32'd0);
    tick_until_valid(10, "t3_deliver");
    chk("t3_pcD", pcD, 32'h100);

    // 4. redirect in the same cycle as a response
    lat = 1;
    tick_until_fire(10, "t4_pre");
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("t4_fire", 32'(obs_fire), 32'd1);
    chk("t4_addr", obs_addr, 32'h100);
    chk("t4_no_kill_wait", 32'(obs_wait), 32'd0);

    // 5. memory not ready for several cycles
    tick(); tick(); tick();
    imem.imem_req_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) held = obs_addr;
      chk("t5_req_valid", 32'(obs_req_valid), 32'd1);
      chk("t5_addr_model", obs_addr, exp_pc);
      chk("t5_addr_stable", obs_addr, held);
      chk("t5_wait", 32'(obs_wait), 32'd1);
      chk("t5_bubble", 32'(validD), 32'd0);
    end
    imem.imem_req_ready = 1'b1;

    // 6. misaligned target, wraparound, reset during an outstanding fetch
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    tick_until_fire(10, "t6_align");
    chk("t6_align_addr", obs_addr, 32'h100);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick_until_valid(10, "t6_top");
    chk("t6_pcD_top", pcD, 32'hFFFF_FFFC);
    chk("t6_pcplus4D_wrap", pcplus4D, 32'h0);
    tick_until_valid(10, "t6_wrap");
    chk("t6_pcD_wrap", pcD, 32'h0);

    lat = 3;
    tick_until_fire(10, "t6_rst_pre");
    tick();
    reset = 1'b1;
    tick();
    chk_reset_outputs("t6_rst");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_rst_no_req", 32'(obs_req_valid), 32'd0);
    end
    reset = 1'b0;
    lat = 1;
    tick_until_fire(10, "t6_post_rst");
    chk("t6_post_rst_addr", obs_addr, RST_PC);
    for (int i = 0; i < 10; i++) tick();
    chk("final_pcD", pcD, exp_pc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
